nvdla_csc_op_sched: RTL and testbench



---
 rtl/nvdla_csc_op_sched_if.sv | 68 ++++++
 rtl/nvdla_csc_op_sched.sv | 140 ++++++++++++++
 tb/tb_nvdla_csc_op_sched.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/nvdla_csc_op_sched_if.sv
// -----------------------------------------------------------------------------
// nvdla_csc_op_sched_if
//
// Groups the handshake signals between the CSC ping-pong scheduler and its
// neighbours: the single-register block (producer pointer, op-enable trigger,
// status readback), the CSC datapath (start/done) and the interrupt logic
// (completion pulse).
//
// Signals
//   producer        group addressed by software writes
//   op_en_trigger   1-cycle pulse: software wrote OP_ENABLE=1 to `producer`
//   dp_op_done      1-cycle pulse: running layer finished
//   consumer        group the datapath executes next or is executing
//   status_0/1      per-group status: 0 IDLE, 1 RUNNING, 2 PENDING
//   reg2dp_op_en_0/1 per-group op-enable flags
//   dp_op_start     1-cycle pulse: datapath starts layer from `consumer`
//   dp2reg_done     1-cycle completion pulse
//   done_group      group that completed, valid while dp2reg_done=1
//   op_en_err       1-cycle pulse: trigger rejected
//
// Modports
//   master  the surrounding logic (register block / datapath side)
//   slave   the scheduler itself
// -----------------------------------------------------------------------------
interface nvdla_csc_op_sched_if;
    logic       producer;
    logic       op_en_trigger;
    logic       dp_op_done;
    logic       consumer;
    logic [1:0] status_0;
    logic [1:0] status_1;
    logic       reg2dp_op_en_0;
    logic       reg2dp_op_en_1;
    logic       dp_op_start;
    logic       dp2reg_done;
    logic       done_group;
    logic       op_en_err;

    modport master (
        output producer,
        output op_en_trigger,
        output dp_op_done,
        input  consumer,
        input  status_0,
        input  status_1,
        input  reg2dp_op_en_0,
        input  reg2dp_op_en_1,
        input  dp_op_start,
        input  dp2reg_done,
        input  done_group,
        input  op_en_err
    );

    modport slave (
        input  producer,
        input  op_en_trigger,
        input  dp_op_done,
        output consumer,
        output status_0,
        output status_1,
        output reg2dp_op_en_0,
        output reg2dp_op_en_1,
        output dp_op_start,
        output dp2reg_done,
        output done_group,
        output op_en_err
    );
endinterface

// File: rtl/nvdla_csc_op_sched.sv
// -----------------------------------------------------------------------------
// nvdla_csc_op_sched
//
// Ping-pong register-group scheduler for CSC. Holds the op-enable flag of the
// two duplicated register groups and runs layers strictly alternately from
// group 0 and group 1 (IDLE -> LAUNCH -> RUN -> DRAIN -> IDLE).
//
// Ports
//   nvdla_core_clk   core clock, rising edge
//   nvdla_core_rstn  asynchronous active-low reset
//   sched            scheduler side of nvdla_csc_op_sched_if (see interface
//                    file for the individual signals)
//
// All outputs are flops. Each output flop is loaded from the next-state value
// of the state it decodes, so e.g. status reflects a trigger one cycle after
// the trigger pulse and nothing combinational reaches an output.
// -----------------------------------------------------------------------------
module nvdla_csc_op_sched (
    input  logic                       nvdla_core_clk,
    input  logic                       nvdla_core_rstn,
    nvdla_csc_op_sched_if.slave        sched
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    localparam logic [1:0] STAT_IDLE    = 2'd0;
    localparam logic [1:0] STAT_RUNNING = 2'd1;
    localparam logic [1:0] STAT_PENDING = 2'd2;

    state_e     state_q, state_d;
    logic       consumer_q, consumer_d;
    logic [1:0] op_en_q, op_en_d;
    logic [1:0] op_en_set;
    logic [1:0] status0_q, status0_d;
    logic [1:0] status1_q, status1_d;
    logic       start_q, start_d;
    logic       done_q, done_d;
    logic       done_group_q, done_group_d;
    logic       err_q, err_d;

    function automatic logic [1:0] grp_status(input logic en,
                                              input logic is_consumer,
                                              input state_e st);
        if (!en)
            return STAT_IDLE;
        else if (is_consumer && (st != ST_IDLE))
            return STAT_RUNNING;
        else
            return STAT_PENDING;
    endfunction

    always_comb begin
        // Trigger is judged against the flag value before any DRAIN clear,
        // so re-enabling the group that is just draining is rejected.
        op_en_set = op_en_q;
        err_d     = 1'b0;
        if (sched.op_en_trigger) begin
            if (op_en_q[sched.producer])
                err_d = 1'b1;
            else
                op_en_set[sched.producer] = 1'b1;
        end

        op_en_d    = op_en_set;
        state_d    = state_q;
        consumer_d = consumer_q;

        case (state_q)
            ST_IDLE: begin
                // Looks at the post-trigger flag so a trigger to the waiting
                // consumer launches in the very next cycle.
                if (op_en_set[consumer_q])
                    state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (sched.dp_op_done)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                op_en_d[consumer_q] = 1'b0;
                consumer_d          = ~consumer_q;
                state_d             = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        start_d      = (state_d == ST_LAUNCH);
        done_d       = (state_d == ST_DRAIN);
        // consumer only toggles when leaving DRAIN, so consumer_d is the
        // draining group whenever done_d is set.
        done_group_d = done_d ? consumer_d : 1'b0;
        status0_d    = grp_status(op_en_d[0], (consumer_d == 1'b0), state_d);
        status1_d    = grp_status(op_en_d[1], (consumer_d == 1'b1), state_d);
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q      <= ST_IDLE;
            consumer_q   <= 1'b0;
            op_en_q      <= 2'b00;
            status0_q    <= STAT_IDLE;
            status1_q    <= STAT_IDLE;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            done_group_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            consumer_q   <= consumer_d;
            op_en_q      <= op_en_d;
            status0_q    <= status0_d;
            status1_q    <= status1_d;
            start_q      <= start_d;
            done_q       <= done_d;
            done_group_q <= done_group_d;
            err_q        <= err_d;
        end
    end

    assign sched.consumer       = consumer_q;
    assign sched.status_0       = status0_q;
    assign sched.status_1       = status1_q;
    assign sched.reg2dp_op_en_0 = op_en_q[0];
    assign sched.reg2dp_op_en_1 = op_en_q[1];
    assign sched.dp_op_start    = start_q;
    assign sched.dp2reg_done    = done_q;
    assign sched.done_group     = done_group_q;
    assign sched.op_en_err      = err_q;

endmodule

// File: tb/tb_nvdla_csc_op_sched.sv
// -----------------------------------------------------------------------------
// tb_nvdla_csc_op_sched
//
// Directed bench for the CSC ping-pong scheduler. Inputs change and outputs
// are sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_nvdla_csc_op_sched;

    logic clk;
    logic rstn;

    nvdla_csc_op_sched_if bus ();

    nvdla_csc_op_sched dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .sched           (bus.slave)
    );

    int total_cnt;
    int bad_cnt;
    int start_cnt;
    int done_cnt;
    int snap;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled on the falling edge away from input changes.
    always @(negedge clk) begin
        if (bus.dp_op_start) start_cnt <= start_cnt + 1;
        if (bus.dp2reg_done) done_cnt  <= done_cnt + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total_cnt++;
        if (got != exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance one cycle; pulse inputs last exactly one cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.op_en_trigger = 1'b0;
        bus.dp_op_done    = 1'b0;
    endtask

    task automatic trig(input logic grp);
        bus.producer      = grp;
        bus.op_en_trigger = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cons"},  bus.consumer,       0);
        chk({tag, "_st0"},   bus.status_0,       0);
        chk({tag, "_st1"},   bus.status_1,       0);
        chk({tag, "_en0"},   bus.reg2dp_op_en_0, 0);
        chk({tag, "_en1"},   bus.reg2dp_op_en_1, 0);
        chk({tag, "_start"}, bus.dp_op_start,    0);
        chk({tag, "_done"},  bus.dp2reg_done,    0);
        chk({tag, "_dgrp"},  bus.done_group,     0);
        chk({tag, "_err"},   bus.op_en_err,      0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        rstn = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        start_cnt = 0;
        done_cnt  = 0;
        rstn      = 1'b0;
        bus.producer      = 1'b0;
        bus.op_en_trigger = 1'b0;
        bus.dp_op_done    = 1'b0;

        // ---------------- reset + single layer ----------------
        repeat (3) tick();
        check_all_zero("rst");
        rstn = 1'b1;
        repeat (2) tick();
        trig(1'b0); tick();                       // LAUNCH
        chk("s1_start",   bus.dp_op_start, 1);
        chk("s1_st0_L",   bus.status_0, 1);
        chk("s1_en0",     bus.reg2dp_op_en_0, 1);
        tick();                                   // RUN
        chk("s1_start_off", bus.dp_op_start, 0);
        chk("s1_st0_R",   bus.status_0, 1);
        repeat (3) tick();
        bus.dp_op_done = 1'b1; tick();            // DRAIN
        chk("s1_done",    bus.dp2reg_done, 1);
        chk("s1_dgrp",    bus.done_group, 0);
        chk("s1_st0_D",   bus.status_0, 1);
        tick();                                   // IDLE
        chk("s1_done_off", bus.dp2reg_done, 0);
        chk("s1_st0_I",   bus.status_0, 0);
        chk("s1_cons",    bus.consumer, 1);
        chk("s1_en0_clr", bus.reg2dp_op_en_0, 0);

        // ---------------- back-to-back ping-pong ----------------
        do_reset();
        trig(1'b0); tick();                       // LAUNCH g0
        tick();                                   // RUN g0
        trig(1'b1); tick();
        chk("pp_st1_pend", bus.status_1, 2);
        chk("pp_st0_run",  bus.status_0, 1);
        chk("pp_err0",     bus.op_en_err, 0);
        tick();
        bus.dp_op_done = 1'b1; tick();            // D+1 DRAIN
        chk("pp_dgrp0",    bus.done_group, 0);
        chk("pp_done0",    bus.dp2reg_done, 1);
        tick();                                   // D+2 IDLE
        chk("pp_cons1",    bus.consumer, 1);
        chk("pp_st1_wait", bus.status_1, 2);
        chk("pp_nostart",  bus.dp_op_start, 0);
        tick();                                   // D+3 LAUNCH g1
        chk("pp_start1",   bus.dp_op_start, 1);
        chk("pp_st1_run",  bus.status_1, 1);
        tick();
        bus.dp_op_done = 1'b1; tick();
        chk("pp_dgrp1",    bus.done_group, 1);
        chk("pp_done1",    bus.dp2reg_done, 1);
        tick();
        chk("pp_cons0",    bus.consumer, 0);
        chk("pp_st1_idle", bus.status_1, 0);

        // ---------------- out-of-order enable ----------------
        do_reset();
        snap = start_cnt;
        trig(1'b1); tick();
        chk("oo_st1_pend", bus.status_1, 2);
        repeat (3) tick();
        chk("oo_nostart",  start_cnt - snap, 0);
        trig(1'b0); tick();
        chk("oo_start0",   bus.dp_op_start, 1);
        chk("oo_cons0",    bus.consumer, 0);
        chk("oo_st1_wait", bus.status_1, 2);
        tick();
        bus.dp_op_done = 1'b1; tick();            // DRAIN g0
        tick();                                   // IDLE
        chk("oo_gap",      bus.dp_op_start, 0);
        tick();                                   // done+3
        chk("oo_start1",   bus.dp_op_start, 1);
        chk("oo_cons1",    bus.consumer, 1);

        // ---------------- rejections + stray done ----------------
        do_reset();
        trig(1'b0); tick();
        tick();                                   // RUN
        trig(1'b0); tick();
        chk("rj_err_run",  bus.op_en_err, 1);
        chk("rj_en0",      bus.reg2dp_op_en_0, 1);
        chk("rj_st0",      bus.status_0, 1);
        tick();
        chk("rj_err_off",  bus.op_en_err, 0);
        bus.dp_op_done = 1'b1; tick();            // DRAIN
        trig(1'b0); tick();                       // trigger in DRAIN cycle
        chk("rj_err_drn",  bus.op_en_err, 1);
        chk("rj_en0_clr",  bus.reg2dp_op_en_0, 0);
        chk("rj_cons1",    bus.consumer, 1);
        snap = done_cnt;
        bus.dp_op_done = 1'b1; tick();            // stray done in IDLE
        tick();
        chk("rj_stray",    done_cnt - snap, 0);
        chk("rj_st0_idle", bus.status_0, 0);
        chk("rj_st1_idle", bus.status_1, 0);
        chk("rj_nostart",  bus.dp_op_start, 0);

        // ---------------- mid-run reset ----------------
        do_reset();
        trig(1'b0); tick();
        tick();                                   // RUN
        trig(1'b1); tick();
        snap = done_cnt;
        rstn = 1'b0;
        #1;
        check_all_zero("mr");
        bus.dp_op_done = 1'b1;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        chk("mr_nodone",   done_cnt - snap, 0);
        trig(1'b0); tick();
        chk("mr_start0",   bus.dp_op_start, 1);
        chk("mr_cons0",    bus.consumer, 0);
        chk("mr_st1",      bus.status_1, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
